// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
// States, funct3 encodings and store lane formatting.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic f3_legal(input logic [2:0] f3);
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  // Store size comes from funct3[1:0]; off is already aligned to that size.
  function automatic logic [3:0] st_strb(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] st_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory valid/ready bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if #(parameter int ADDR_WIDTH = 32);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-3:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_wstrb;
  logic                  mem_ready;
  logic [31:0]           mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/load_store_unit_load_align.sv
// Load formatter: picks the byte/half lane from a read word and sign/zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[8*off +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    result = {{24{b[7]}}, b};
      F3_BU:   result = {24'h0, b};
      F3_H:    result = {{16{h[15]}}, h};
      F3_HU:   result = {16'h0, h};
      F3_W:    result = rdata;
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: IDLE -> BUSY -> DONE per access, with a response timeout.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned H/W accesses instead of aligning them down.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memread_mem,
  input  logic                  memwrite_mem,
  input  logic [2:0]            funct3_mem,
  input  logic [ADDR_WIDTH-1:0] alu_result_mem,
  input  logic [31:0]           write_data_memory_mem,
  output logic [31:0]           data_from_memory_mem,
  output logic                  stall_mem,
  output logic                  bus_err,
  load_store_unit_if.master     mem
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  req_q, req_d, we_q, we_d, err_q, err_d;
  logic [ADDR_WIDTH-3:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d, data_q, data_d;
  logic [3:0]            wstrb_q, wstrb_d;

  logic        pending, legal;
  logic [1:0]  off;
  logic [31:0] ld_fmt;

  assign pending = memread_mem | memwrite_mem;

  // Low address bits below the access size are dropped so H/W always hit an aligned lane.
  always_comb begin
    off = alu_result_mem[1:0];
    case (funct3_mem[1:0])
      2'b01:   off[0] = 1'b0;
      2'b10:   off    = 2'b00;
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = (funct3_mem[1:0] == 2'b01 && alu_result_mem[0]) ||
                    (funct3_mem[1:0] == 2'b10 && alu_result_mem[1:0] != 2'b00);
  assign legal    = f3_legal(funct3_mem) && !misalign;
`else
  assign legal    = f3_legal(funct3_mem);
`endif

  lsu_load_align u_align (
    .rdata  (mem.mem_rdata),
    .off    (off),
    .funct3 (funct3_mem),
    .result (ld_fmt)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    data_d    = data_q;
    err_d     = 1'b0;
    stall_mem = 1'b0;
    case (state_q)
      IDLE: if (pending) begin
        // Stall even for an illegal access so it is retired in DONE, not skipped.
        stall_mem = 1'b1;
        if (legal) begin
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = memwrite_mem;
          addr_d  = alu_result_mem[ADDR_WIDTH-1:2];
          wdata_d = memwrite_mem ? st_data(funct3_mem, write_data_memory_mem) : '0;
          wstrb_d = memwrite_mem ? st_strb(funct3_mem, off) : 4'b0000;
        end else begin
          state_d = DONE;
          err_d   = 1'b1;
          data_d  = '0;
        end
      end
      BUSY: begin
        stall_mem = 1'b1;
        if (mem.mem_ready) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          wstrb_d = 4'b0000;
          data_d  = (memread_mem && !memwrite_mem) ? ld_fmt : '0;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          wstrb_d = 4'b0000;
          err_d   = 1'b1;
          data_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign mem.mem_req           = req_q;
  assign mem.mem_we            = we_q;
  assign mem.mem_addr          = addr_q;
  assign mem.mem_wdata         = wdata_q;
  assign mem.mem_wstrb         = wstrb_q;
  assign data_from_memory_mem  = data_q;
  assign bus_err               = err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random accesses
// against an arithmetic reference model.
module tb_load_store_unit;
  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        memread, memwrite;
  logic [2:0]  f3_in;
  logic [31:0] addr_in, wd_in;
  logic [31:0] dout;
  logic        stall, berr;
  int          n_chk = 0, n_pass = 0;

  load_store_unit_if mem_if ();

  load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .memread_mem           (memread),
    .memwrite_mem          (memwrite),
    .funct3_mem            (f3_in),
    .alu_result_mem        (addr_in),
    .write_data_memory_mem (wd_in),
    .data_from_memory_mem  (dout),
    .stall_mem             (stall),
    .bus_err               (berr),
    .mem                   (mem_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // ---- reference model: plain arithmetic on access size and byte offset ----
  function automatic bit m_legal(input logic [2:0] f3, input logic [31:0] a);
    bit ok = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
`ifdef LSU_MISALIGN_TRAP_EN
    if (f3[1:0] == 2'b01 && a[0]) ok = 0;
    if (f3[1:0] == 2'b10 && a[1:0] != 2'b00) ok = 0;
`endif
    return ok;
  endfunction

  function automatic int m_nb(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic int m_off(input logic [2:0] f3, input logic [31:0] a);
    return int'(a[1:0]) & ~(m_nb(f3) - 1);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    int nb = m_nb(f3);
    longint v = longint'(w >> (8 * m_off(f3, a))) % (longint'(1) << (8 * nb));
    if (!f3[2] && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    return 32'(((1 << m_nb(f3)) - 1) << m_off(f3, a));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = wd[8*(i % m_nb(f3)) +: 8];
    return v;
  endfunction

  // One instruction in MEM: called and returns at posedge+1. dly<0 means memory never answers.
  task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdw,
                        input int dly);
    bit legal;
    int n_req = 0, n_stall = 0, cyc = 0;
    bit req_seen = 0;
    logic [31:0] ex_data;
    memread = rd; memwrite = wr; f3_in = f3; addr_in = a; wd_in = wd;
    mem_if.mem_ready = 1'b0; mem_if.mem_rdata = $urandom;
    if (!rd && !wr) begin
      mem_if.mem_ready = 1'b1;
      @(negedge clk);
      check({tag, " nostall"}, 32'(stall), 32'd0);
      check({tag, " noreq"}, 32'(mem_if.mem_req), 32'd0);
      mem_if.mem_ready = 1'b0;
      @(posedge clk); #1;
      return;
    end
    legal = m_legal(f3, a);
    @(negedge clk);
    while (stall === 1'b1 && cyc < 400) begin
      n_stall++;
      if (mem_if.mem_req === 1'b1) begin
        if (!req_seen) begin
          req_seen = 1;
          check({tag, " we"}, 32'(mem_if.mem_we), 32'(wr));
          check({tag, " addr"}, 32'(mem_if.mem_addr), a >> 2);
          check({tag, " wstrb"}, 32'(mem_if.mem_wstrb), wr ? m_strb(f3, a) : 32'd0);
          if (wr) check({tag, " wdata"}, mem_if.mem_wdata, m_wdata(f3, wd));
        end
        n_req++;
        if (dly >= 0 && n_req == dly + 1) begin
          mem_if.mem_ready = 1'b1; mem_if.mem_rdata = rdw;
        end
      end
      @(negedge clk);
      cyc++;
    end
    mem_if.mem_ready = 1'b0; mem_if.mem_rdata = $urandom;
    ex_data = (legal && dly >= 0 && rd && !wr) ? m_load(f3, a, rdw) : 32'd0;
    check({tag, " stall_cycles"}, 32'(n_stall), !legal ? 32'd1 : (dly >= 0 ? 32'(dly + 2) : 32'(TO + 1)));
    check({tag, " req_issued"}, 32'(req_seen), 32'(legal));
    check({tag, " data"}, dout, ex_data);
    check({tag, " bus_err"}, 32'(berr), 32'(!legal || dly < 0));
    @(posedge clk); #1;
    memread = 1'b0; memwrite = 1'b0;
    @(negedge clk);
    check({tag, " data_held"}, dout, ex_data);
    check({tag, " err_pulse"}, 32'(berr), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; memread = 1'b0; memwrite = 1'b0; f3_in = 3'b010; addr_in = '0; wd_in = '0;
    mem_if.mem_ready = 1'b0; mem_if.mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst req", 32'(mem_if.mem_req), 32'd0);
    check("rst we", 32'(mem_if.mem_we), 32'd0);
    check("rst wstrb", 32'(mem_if.mem_wstrb), 32'd0);
    check("rst data", dout, 32'd0);
    check("rst err", 32'(berr), 32'd0);
    check("rst stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    access("lw_0x100", 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    access("lb_0x103", 1, 0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0);
    access("lbu_0x103", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80112233, 1);
    access("lh_0x102", 1, 0, 3'b001, 32'h102, 32'h0, 32'h9ABC1234, 2);
    access("sh_0x102", 0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 0);
    access("sb_0x101", 0, 1, 3'b000, 32'h101, 32'h000000A5, 32'h0, 1);
    access("sw_0x104", 0, 1, 3'b010, 32'h104, 32'hCAFEF00D, 32'h0, 0);
    access("rw_both", 1, 1, 3'b010, 32'h108, 32'h11112222, 32'h55556666, 0);
    access("reserved_f3", 1, 0, 3'b011, 32'h10C, 32'h0, 32'h0, 0);
    access("no_access", 0, 0, 3'b010, 32'h0, 32'h0, 32'h0, 0);
    access("lw_0x102", 1, 0, 3'b010, 32'h102, 32'h0, 32'h76543210, 0);
    access("lh_0x101", 1, 0, 3'b001, 32'h101, 32'h0, 32'h8001FFFE, 0);
    access("timeout", 1, 0, 3'b010, 32'h200, 32'h0, 32'h0, -1);

    // Reset in the middle of BUSY abandons the request.
    memread = 1'b1; f3_in = 3'b010; addr_in = 32'h300; mem_if.mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("busy req", 32'(mem_if.mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1; memread = 1'b0;
    @(negedge clk);
    check("rstbusy req", 32'(mem_if.mem_req), 32'd0);
    check("rstbusy stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    access("after_rst", 1, 0, 3'b101, 32'h302, 32'h0, 32'hF00D1234, 0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      access($sformatf("rnd%0d", i), op[0], op[1], 3'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
